dm_access_unit: RTL and testbench

- Data-memory responder at the far end of the CPU's MemWrite/dm_ctrl memory interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs width/sign formatting (word, half, half-unsigned, byte, byte-unsigned) against an internal word-wide synchronous RAM. Sub-word stores are done by read-modify-write.
- Returns a single-cycle response carrying load data or a misalignment/illegal-code error flag.

---
 rtl/dm_access_unit.sv | 144 ++++++++++++++
 tb/tb_dm_access_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory responder: single-outstanding load/store unit over a word-wide synchronous RAM,
// with sub-word formatting on loads and read-modify-write for sub-word stores.
module dm_access_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_w,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    accept, req_err, ram_we;
  logic [2:0]              ctrl_q;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [31:0]             rd_word_q, wr_word_q, rdata_q;
  logic                    err_q;
  logic [31:0]             lane_shift, load_fmt, lane_data, merged;
  logic [3:0]              lane_be;
  logic [31:0]             ram_q [2**ADDR_WIDTH];
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];
  assign accept           = req_valid & req_ready;

  always_comb begin
    case (dm_ctrl)
      3'b000:         req_err = (addr[1:0] != 2'b00);
      3'b001, 3'b010: req_err = addr[0];
      3'b011, 3'b100: req_err = 1'b0;
      default:        req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)              state_d = S_RESP;
          else if (!mem_w)          state_d = S_LOAD;
          else if (dm_ctrl == 3'b0) state_d = S_WRITE;
          else                      state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // rst gates both the handshake and the RAM write so an aborted store leaves memory intact
  always_comb begin
    req_ready = (state_q == S_IDLE) & ~rst;
    rsp_valid = (state_q == S_RESP);
    ram_we    = (state_q == S_WRITE) & ~rst;
  end

  assign lane_shift = rd_word_q >> {off_q, 3'b000};

  always_comb begin
    case (ctrl_q)
      3'b001:  load_fmt = {{16{lane_shift[15]}}, lane_shift[15:0]};
      3'b010:  load_fmt = {16'h0, lane_shift[15:0]};
      3'b011:  load_fmt = {{24{lane_shift[7]}}, lane_shift[7:0]};
      3'b100:  load_fmt = {24'h0, lane_shift[7:0]};
      default: load_fmt = rd_word_q;
    endcase
  end

  always_comb begin
    if (ctrl_q == 3'b001 || ctrl_q == 3'b010) begin
      lane_be   = off_q[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{wdata_q}};
    end else begin
      lane_be   = 4'b0001 << off_q;
      lane_data = {4{wdata_q[7:0]}};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = lane_be[gi] ? lane_data[8*gi +: 8] : rd_word_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_q    <= dm_ctrl;
        off_q     <= addr[1:0];
        idx_q     <= addr[ADDR_WIDTH+1:2];
        wdata_q   <= wdata[15:0];
        wr_word_q <= wdata;
        if (req_err) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end
      end
      case (state_q)
        S_LOAD: begin
          rdata_q <= load_fmt;
          err_q   <= 1'b0;
        end
        S_RMW_RD: wr_word_q <= merged;
        S_WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx_q] <= wr_word_q;
    if (accept) rd_word_q <= ram_q[addr[ADDR_WIDTH+1:2]];
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized and directed bench for dm_access_unit against a word-array memory model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_w = 1'b0;
  logic [2:0]  dm_ctrl = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [256];

  always #5 clk = ~clk;

  dm_access_unit #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_w(mem_w), .dm_ctrl(dm_ctrl), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: memory as a word array, sub-word access via shifts and masks.
  task automatic model(input bit w, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit e,
                       output int lat);
    int unsigned idx, off, v, msk;
    idx = (a / 4) % 256;
    off = a % 4;
    e   = (c > 4) || (c == 0 && off != 0) || ((c == 1 || c == 2) && (off % 2 == 1));
    rd  = 32'h0;
    if (e) begin
      lat = 1;
    end else if (!w) begin
      lat = 2;
      case (c)
        3'd0: rd = mdl[idx];
        3'd1: begin v = (mdl[idx] >> (8*off)) & 32'hFFFF; rd = (v >= 32'h8000) ? v - 32'h10000 : v; end
        3'd2: rd = (mdl[idx] >> (8*off)) & 32'hFFFF;
        3'd3: begin v = (mdl[idx] >> (8*off)) & 32'hFF; rd = (v >= 32'h80) ? v - 32'h100 : v; end
        default: rd = (mdl[idx] >> (8*off)) & 32'hFF;
      endcase
    end else if (c == 0) begin
      lat = 2;
      mdl[idx] = wd;
    end else begin
      lat = 3;
      msk = (c <= 2) ? 32'hFFFF : 32'hFF;
      mdl[idx] = (mdl[idx] & ~(msk << (8*off))) | ((wd & msk) << (8*off));
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic do_req(input bit w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          exp_e;
    int          exp_lat, lat;
    model(w, c, a, wd, exp_rd, exp_e, exp_lat);
    mem_w = w; dm_ctrl = c; addr = a; wdata = wd; req_valid = 1'b1;
    #1 check("req_ready_idle", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 8 && lat == 99; i++) begin
      @(negedge clk);
      if (rsp_valid) lat = i;
    end
    check("latency", lat, exp_lat);
    check("rdata", rdata, exp_rd);
    check("err", {31'h0, err}, {31'h0, exp_e});
    $display("txn w=%0d ctrl=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             w, c, a, wd, rdata, err, lat);
    @(negedge clk);
    check("rsp_pulse", {31'h0, rsp_valid}, 32'd0);
    check("ready_after", {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsps;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_ready", {31'h0, req_ready}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_req(1'b1, 3'd0, 32'(i * 4), $urandom);

    do_req(1'b1, 3'd0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h10, 32'h0);
    do_req(1'b0, 3'd3, 32'h13, 32'h0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    do_req(1'b0, 3'd1, 32'h12, 32'h0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1'b1, 3'd3, 32'h11, 32'h55);
    do_req(1'b1, 3'd1, 32'h12, 32'h1234);
    do_req(1'b0, 3'd0, 32'h10, 32'h0);
    do_req(1'b0, 3'd1, 32'h21, 32'h0);
    do_req(1'b1, 3'd0, 32'h22, 32'hFFFFFFFF);
    do_req(1'b1, 3'd6, 32'h20, 32'hFFFFFFFF);
    do_req(1'b0, 3'd0, 32'h20, 32'h0);

    // Held request: one accept per three-cycle load
    mem_w = 1'b0; dm_ctrl = 3'd0; addr = 32'h10; req_valid = 1'b1;
    acc = 0; rsps = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (rsp_valid) rsps++;
    end
    req_valid = 1'b0;
    check("held_accepts", acc, 4);
    check("held_rsps", rsps, 4);
    check("held_rdata", rdata, mdl[4]);
    @(negedge clk);

    // Reset during WRITE aborts the store
    do_req(1'b1, 3'd0, 32'h30, 32'h11111111);
    mem_w = 1'b1; dm_ctrl = 3'd0; addr = 32'h30; wdata = 32'hAAAAAAAA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_ready_in_rst", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_ready", {31'h0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_rsp", {31'h0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    do_req(1'b0, 3'd0, 32'h30, 32'h0);

    do_req(1'b1, 3'd0, 32'h400, 32'hCAFEF00D);
    do_req(1'b0, 3'd0, 32'h000, 32'h0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
